read_ptr: RTL and testbench

Read-side pointer and empty-flag generator for the dual-clock FIFO, the counterpart to the write-pointer block. It runs entirely in the read clock domain. It advances a binary/Gray read pointer on accepted reads and synchronizes the Gray write pointer from the write domain through two flops. From these it produces the memory read address, the registered empty and almost-empty flags, a fill level and a sticky underflow error. Its Gray pointer output is synchronized into the write domain, where it feeds the write pointer's full detection.

---
 rtl/read_ptr.sv | 79 +++++++
 tb/tb_read_ptr.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/read_ptr.sv
// Read-domain pointer for the dual-clock FIFO: binary/Gray read counter, two-flop
// write-pointer synchronizer, registered empty/almost-empty/level and sticky underflow.
module read_ptr #(
    parameter int ADDR_SIZE    = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE:0]   wr_ptr_i,
    input  logic                 inc_i,
    output logic [ADDR_SIZE:0]   ptr_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 fifo_empty_o,
    output logic                 almost_empty_o,
    output logic [ADDR_SIZE:0]   level_o,
    output logic                 underflow_o
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic [PW-1:0] r_wq1;
    logic [PW-1:0] r_wq2;
    logic [PW-1:0] r_level;
    logic          r_empty;
    logic          r_almost;
    logic          r_underflow;

    logic          w_rd_en;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_level_next;

    // inc_i is a request; it is accepted only when the registered empty flag is low,
    // otherwise it is dropped and recorded as underflow.
    assign w_rd_en     = inc_i & ~r_empty;
    assign w_bin_next  = r_bin + {{ADDR_SIZE{1'b0}}, w_rd_en};
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
        assign w_wbin[gi] = ^r_wq2[PW-1:gi];
    end

    // Modulo subtraction stays correct across the pointer wrap thanks to the extra MSB.
    assign w_level_next = w_wbin - w_bin_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bin       <= '0;
            r_gray      <= '0;
            r_wq1       <= '0;
            r_wq2       <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_almost    <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_bin       <= w_bin_next;
            r_gray      <= w_gray_next;
            r_wq1       <= wr_ptr_i;
            r_wq2       <= r_wq1;
            r_level     <= w_level_next;
            r_empty     <= (w_gray_next == r_wq2);
            r_almost    <= (w_level_next <= AE_LEVEL);
            r_underflow <= r_underflow | (inc_i & r_empty);
        end
    end

    assign ptr_o          = r_gray;
    assign addr_o         = r_bin[ADDR_SIZE-1:0];
    assign fifo_empty_o   = r_empty;
    assign almost_empty_o = r_almost;
    assign level_o        = r_level;
    assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_read_ptr.sv
// Bench for read_ptr: directed scenarios plus random traffic, checked against a
// count-based reference model of read/write positions.
module tb_read_ptr;

    localparam int AS    = 3;
    localparam int AE    = 1;
    localparam int PW    = AS + 1;
    localparam int DEPTH = 1 << AS;
    localparam int MOD   = 1 << PW;

    logic          clk_i;
    logic          rst_i;
    logic [PW-1:0] wr_ptr_i;
    logic          inc_i;
    logic [PW-1:0] ptr_o;
    logic [AS-1:0] addr_o;
    logic          fifo_empty_o;
    logic          almost_empty_o;
    logic [PW-1:0] level_o;
    logic          underflow_o;

    read_ptr #(.ADDR_SIZE(AS), .ALMOST_EMPTY(AE)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_ptr_i       (wr_ptr_i),
        .inc_i          (inc_i),
        .ptr_o          (ptr_o),
        .addr_o         (addr_o),
        .fifo_empty_o   (fifo_empty_o),
        .almost_empty_o (almost_empty_o),
        .level_o        (level_o),
        .underflow_o    (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: positions as plain counts; w1/w2 are the write position as
    // seen one and two edges after it was presented.
    int m_rbin;
    int m_w1;
    int m_w2;
    int m_level;
    bit m_empty;
    bit m_under;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ptr"},   32'(ptr_o),          32'(to_gray(m_rbin)));
        chk({tag, ".addr"},  32'(addr_o),         32'(m_rbin % DEPTH));
        chk({tag, ".empty"}, 32'(fifo_empty_o),   32'(m_empty));
        chk({tag, ".almost"},32'(almost_empty_o), 32'(m_level <= AE));
        chk({tag, ".level"}, 32'(level_o),        32'(m_level));
        chk({tag, ".under"}, 32'(underflow_o),    32'(m_under));
    endtask

    task automatic model_reset();
        m_rbin  = 0;
        m_w1    = 0;
        m_w2    = 0;
        m_level = 0;
        m_empty = 1'b1;
        m_under = 1'b0;
    endtask

    // One clock: present inputs, take the edge, advance the model, check #1 later.
    task automatic tick(input string tag, input bit inc, input int wb);
        bit rd;
        inc_i    = inc;
        wr_ptr_i = to_gray(wb);
        @(posedge clk_i);
        rd = inc && !m_empty;
        if (inc && m_empty) m_under = 1'b1;
        m_rbin  = (m_rbin + int'(rd)) % MOD;
        m_level = (m_w2 - m_rbin + MOD) % MOD;
        m_empty = (m_level == 0);
        m_w2    = m_w1;
        m_w1    = wb % MOD;
        #1;
        chk_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        rst_i = 1'b0;
        inc_i = 1'b0;
        wr_ptr_i = '0;
        #1;
        model_reset();
        chk_all(tag);
        @(posedge clk_i);
        #1;
        chk_all(tag);
        rst_i = 1'b1;
    endtask

    int wb;

    initial begin
        rst_i    = 1'b1;
        inc_i    = 1'b0;
        wr_ptr_i = '0;
        model_reset();
        #2;
        apply_reset("reset0");

        // Fill to 4, then reset mid-run.
        for (int i = 0; i < 4; i++) tick("fill_a", 1'b0, 4);
        chk("fill_a.level4", 32'(level_o), 32'd4);
        apply_reset("reset_mid");

        // Fill visibility: empty must still be set after 2 edges, clear after 3.
        tick("fill_b1", 1'b0, 4);
        tick("fill_b2", 1'b0, 4);
        chk("fill_b2.still_empty", 32'(fifo_empty_o), 32'd1);
        tick("fill_b3", 1'b0, 4);
        chk("fill_b3.level", 32'(level_o), 32'd4);
        chk("fill_b3.empty", 32'(fifo_empty_o), 32'd0);

        // Drain with 4 reads, then a 5th request while empty.
        for (int i = 0; i < 4; i++) tick("drain", 1'b1, 4);
        chk("drain.ptr_last", 32'(ptr_o), 32'b0110);
        chk("drain.empty_last", 32'(fifo_empty_o), 32'd1);
        tick("drain_extra", 1'b1, 4);
        chk("drain_extra.ptr_hold", 32'(ptr_o), 32'b0110);
        apply_reset("reset_full");

        // Full level: 8 entries with the read pointer at 0.
        for (int i = 0; i < 3; i++) tick("full", 1'b0, 8);
        chk("full.level8", 32'(level_o), 32'b1000);
        apply_reset("reset_wrap");

        // Wrap: walk the read pointer to 14, then write 3 more and read across 15->0.
        for (int i = 0; i < 3; i++) tick("wrap_fill", 1'b0, 7);
        for (int i = 0; i < 7; i++) tick("wrap_rd1", 1'b1, 7);
        for (int i = 0; i < 3; i++) tick("wrap_fill2", 1'b0, 14);
        for (int i = 0; i < 7; i++) tick("wrap_rd2", 1'b1, 14);
        chk("wrap.rbin14", 32'(ptr_o), 32'b1001);
        for (int i = 0; i < 3; i++) tick("wrap_fill3", 1'b0, 17);
        chk("wrap.level3", 32'(level_o), 32'd3);
        for (int i = 0; i < 3; i++) tick("wrap_rd3", 1'b1, 17);
        chk("wrap.ptr_after", 32'(ptr_o), 32'b0001);
        chk("wrap.empty_after", 32'(fifo_empty_o), 32'd1);
        apply_reset("reset_under");

        // Underflow: sticky through later normal reads.
        tick("under_pulse", 1'b1, 0);
        chk("under.set", 32'(underflow_o), 32'd1);
        for (int i = 0; i < 3; i++) tick("under_fill", 1'b0, 3);
        for (int i = 0; i < 3; i++) tick("under_rd", 1'b1, 3);
        chk("under.sticky", 32'(underflow_o), 32'd1);
        apply_reset("reset_rand");

        // Random traffic: writer never exceeds the depth relative to the model reader.
        wb = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1 && ((wb - m_rbin + MOD) % MOD) < DEPTH)
                wb = (wb + 1) % MOD;
            tick("rand", 1'($urandom_range(0, 2) != 0), wb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
